// File: rtl/rf_wb_pkg.sv
// Shared defaults and source encoding for the register-file writeback arbiter.
package rf_wb_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_ADDR_DEPTH = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } wb_src_e;

endpackage

// File: rtl/rf_wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, x0 never busy.
module rf_wb_scoreboard
    import rf_wb_pkg::*;
#(
    parameter int ADDR_DEPTH = RF_ADDR_DEPTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_en_i,
    input  logic [ADDR_WIDTH-1:0] clr_rd_i,
    input  logic                  set_en_i,
    input  logic [ADDR_WIDTH-1:0] set_rd_i,
    output logic [ADDR_DEPTH-1:0] busy_o
);

    logic [ADDR_DEPTH-1:0] busy_q, busy_d;

    // Set is applied after clear so a new reservation survives a same-cycle commit.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) busy_d[clr_rd_i] = 1'b0;
        if (set_en_i) busy_d[set_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges ALU and load writebacks into one registered RF write port with load anti-starvation.
// Optional read-forwarding ports are built when RF_WB_BYPASS_EN is defined.
module rf_writeback_arbiter
    import rf_wb_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_DEPTH = RF_ADDR_DEPTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int MAX_WAIT   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] ld_rd,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  rsv_valid,
    input  logic [ADDR_WIDTH-1:0] rsv_rd,
`ifdef RF_WB_BYPASS_EN
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [ADDR_WIDTH-1:0] A2,
    output logic                  fwd_hit1,
    output logic                  fwd_hit2,
    output logic [DATA_WIDTH-1:0] fwd_data1,
    output logic [DATA_WIDTH-1:0] fwd_data2,
`endif
    output logic                  WE3,
    output logic [ADDR_WIDTH-1:0] A3,
    output logic [DATA_WIDTH-1:0] WD3,
    output logic [ADDR_DEPTH-1:0] busy
);

    localparam int WCW = $clog2(MAX_WAIT + 1);

    logic [WCW-1:0]        wcnt_q, wcnt_d;
    logic                  we3_q, we3_d;
    logic [ADDR_WIDTH-1:0] a3_q, a3_d;
    logic [DATA_WIDTH-1:0] wd3_q, wd3_d;
    logic                  starve, alu_xfer, ld_xfer;
    wb_src_e               src;

    // Ready depends only on valids and the starve flag, never on data.
    assign starve    = (wcnt_q == WCW'(MAX_WAIT));
    assign alu_ready = !starve;
    assign ld_ready  = starve || !alu_valid;
    assign alu_xfer  = alu_valid && alu_ready;
    assign ld_xfer   = ld_valid && ld_ready;
    assign src       = alu_xfer ? SRC_ALU : SRC_LD;

    always_comb begin
        we3_d  = 1'b0;
        a3_d   = a3_q;
        wd3_d  = wd3_q;
        wcnt_d = wcnt_q;
        if (alu_xfer || ld_xfer) begin
            a3_d  = (src == SRC_ALU) ? alu_rd   : ld_rd;
            wd3_d = (src == SRC_ALU) ? alu_data : ld_data;
            we3_d = (a3_d != '0);
        end
        // Starve pins ld_ready high, so the counter cannot run past MAX_WAIT.
        if (ld_xfer)                    wcnt_d = '0;
        else if (ld_valid && !ld_ready) wcnt_d = wcnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we3_q  <= 1'b0;
            a3_q   <= '0;
            wd3_q  <= '0;
            wcnt_q <= '0;
        end else begin
            we3_q  <= we3_d;
            a3_q   <= a3_d;
            wd3_q  <= wd3_d;
            wcnt_q <= wcnt_d;
        end
    end

    rf_wb_scoreboard #(
        .ADDR_DEPTH (ADDR_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .clr_en_i (we3_q),
        .clr_rd_i (a3_q),
        .set_en_i (rsv_valid && (rsv_rd != '0)),
        .set_rd_i (rsv_rd),
        .busy_o   (busy)
    );

    assign WE3 = we3_q;
    assign A3  = a3_q;
    assign WD3 = wd3_q;

`ifdef RF_WB_BYPASS_EN
    // Covers the commit cycle, when the RF read still returns the old value.
    assign fwd_hit1  = we3_q && (A1 == a3_q) && (A1 != '0);
    assign fwd_hit2  = we3_q && (A2 == a3_q) && (A2 != '0);
    assign fwd_data1 = wd3_q;
    assign fwd_data2 = wd3_q;
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter; bypass vectors run when RF_WB_BYPASS_EN is defined.
module tb_rf_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, ld_valid, rsv_valid;
    logic        alu_ready, ld_ready;
    logic [4:0]  alu_rd, ld_rd, rsv_rd;
    logic [31:0] alu_data, ld_data;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [31:0] busy;
`ifdef RF_WB_BYPASS_EN
    logic [4:0]  A1, A2;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_writeback_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .rsv_valid (rsv_valid),
        .rsv_rd    (rsv_rd),
`ifdef RF_WB_BYPASS_EN
        .A1        (A1),
        .A2        (A2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2),
`endif
        .WE3       (WE3),
        .A3        (A3),
        .WD3       (WD3),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A reservation is only legal on a free register or one being released this cycle.
    always @(negedge clk) begin
        if (!rst && rsv_valid && rsv_rd != 5'd0)
            check("dbl_rsv", busy[rsv_rd] && !(WE3 && A3 == rsv_rd), 1'b0);
    end

    initial begin
        rst = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid  = 0; ld_rd  = 0; ld_data  = 0;
        rsv_valid = 0; rsv_rd = 0;
`ifdef RF_WB_BYPASS_EN
        A1 = 0; A2 = 0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_we3", WE3, 0);
        check("rst_a3", A3, 0);
        check("rst_wd3", WD3, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_rdy", alu_ready, 1);
        check("rst_ld_rdy", ld_ready, 1);

        // ALU beat with idle load
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        #1;
        check("t1_alu_rdy", alu_ready, 1);
        check("t1_ld_rdy", ld_ready, 0);
        tick();
        alu_valid = 0;
        check("t1_we3", WE3, 1);
        check("t1_a3", A3, 5);
        check("t1_wd3", WD3, 32'hDEADBEEF);

        // Both sources valid: ALU wins three times, then load is forced through
        alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
        ld_valid  = 1; ld_rd  = 2; ld_data  = 32'h22;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("t2_alu_rdy", alu_ready, 1);
            check("t2_ld_rdy", ld_ready, 0);
            tick();
            check("t2_a3_alu", A3, 1);
        end
        check("t2_starve_alu_rdy", alu_ready, 0);
        check("t2_starve_ld_rdy", ld_ready, 1);
        tick();
        check("t2_we3_ld", WE3, 1);
        check("t2_a3_ld", A3, 2);
        check("t2_wd3_ld", WD3, 32'h22);
        check("t2_wcnt", dut.wcnt_q, 0);
        check("t2_alu_rdy_after", alu_ready, 1);
        alu_valid = 0; ld_valid = 0;
        #1;

        // Write to x0 is accepted but never enables the RF
        alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
        #1;
        check("t3_alu_rdy", alu_ready, 1);
        tick();
        alu_valid = 0;
        check("t3_we3", WE3, 0);
        check("t3_wd3", WD3, 32'h55);
        check("t3_busy", busy, 0);

        // Reserve r7, commit it via a load
        rsv_valid = 1; rsv_rd = 7;
        tick();
        rsv_valid = 0;
        check("t4_busy_c1", busy[7], 1);
        tick();
        check("t4_busy_c2", busy[7], 1);
        tick();
        ld_valid = 1; ld_rd = 7; ld_data = 32'h77;
        #1;
        check("t4_ld_rdy", ld_ready, 1);
        check("t4_busy_c3", busy[7], 1);
        tick();
        ld_valid = 0;
        check("t4_we3", WE3, 1);
        check("t4_a3", A3, 7);
        check("t4_busy_c4", busy[7], 1);
        tick();
        check("t4_busy_c5", busy[7], 0);

        // Re-reservation in the commit cycle keeps r7 busy
        rsv_valid = 1; rsv_rd = 7;
        tick();
        rsv_valid = 0;
        alu_valid = 1; alu_rd = 7; alu_data = 32'h99;
        tick();
        alu_valid = 0;
        check("t4_we3_same", WE3, 1);
        rsv_valid = 1; rsv_rd = 7;
        tick();
        rsv_valid = 0;
        check("t4_busy_same", busy[7], 1);
        tick();
        check("t4_busy_hold", busy[7], 1);

        // Reset with a commit in flight and busy = 0xF0
        for (int r = 4; r < 7; r++) begin
            rsv_valid = 1; rsv_rd = 5'(r);
            tick();
        end
        rsv_valid = 0;
        alu_valid = 1; alu_rd = 8; alu_data = 32'hAB;
        tick();
        check("t5_pre_we3", WE3, 1);
        check("t5_pre_busy", busy, 32'h0000_00F0);
        rst = 1;
        tick();
        rst = 0;
        #1;
        check("t5_we3", WE3, 0);
        check("t5_a3", A3, 0);
        check("t5_wd3", WD3, 0);
        check("t5_busy", busy, 0);
        check("t5_alu_rdy", alu_ready, 1);
        check("t5_ld_rdy", ld_ready, 0);
        alu_valid = 0; ld_valid = 1;
        #1;
        check("t5_ld_rdy_idle", ld_ready, 1);
        tick();
        ld_valid = 0;
        tick();

`ifdef RF_WB_BYPASS_EN
        alu_valid = 1; alu_rd = 9; alu_data = 32'h1234;
        tick();
        alu_valid = 0;
        A1 = 9; A2 = 0;
        #1;
        check("t6_hit1", fwd_hit1, 1);
        check("t6_data1", fwd_data1, 32'h1234);
        check("t6_hit2_x0", fwd_hit2, 0);
        A1 = 3; A2 = 9;
        #1;
        check("t6_hit1_miss", fwd_hit1, 0);
        check("t6_hit2", fwd_hit2, 1);
        tick();
        check("t6_hit2_idle", fwd_hit2, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
